// File: rtl/key_pkg.sv
// Shared types and default timing for the key event controller.
// Holds the FSM state encoding and the default cycle counts.
package key_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } key_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 50_000_000;
    localparam int DEF_GAP_CYCLES      = 15_000_000;
    localparam int DEF_REPEAT_CYCLES   = 10_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_filter.sv
// Debounce filter for an active-low raw key: two-flop synchroniser, then the
// output only follows the input after DEBOUNCE_CYCLES consecutive disagreeing samples.
module key_filter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          out_q;
    logic [CW-1:0] cnt_q;

    // Idle level of the raw key is high, so everything resets to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            out_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            if (sync2_q == out_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                out_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign key_o = out_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: classifies debounced key activity into short, double,
// long and auto-repeat strobes with one shared saturating cycle counter.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic busy
);

    localparam int CNT_TOP = max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
    localparam int CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    logic          filt_out;
    logic          level_q;
    logic          press_edge;
    logic          release_edge;
    key_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          short_q;
    logic          double_q;
    logic          long_q;
    logic          repeat_q;

    key_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_filter (
        .clk   (clk),
        .rst_n (~rst),
        .key_i (key_in),
        .key_o (filt_out)
    );

    assign key_level    = ~filt_out;
    assign press_edge   = key_level & ~level_q;
    assign release_edge = ~key_level & level_q;

    // Every branch that changes state also clears cnt_q; otherwise it saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            level_q  <= key_level;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            cnt_q    <= (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

            case (state_q)
                ST_IDLE: begin
                    if (press_edge) begin
                        state_q <= ST_PRESS1;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS1: begin
                    if (release_edge) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                    end else if (key_level && cnt_q == LONG_LAST) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // A press landing on the timeout cycle still counts as a double click.
                    if (press_edge) begin
                        state_q <= ST_PRESS2;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                    end
                end
                ST_PRESS2: begin
                    if (release_edge) begin
                        state_q  <= ST_IDLE;
                        cnt_q    <= '0;
                        double_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (release_edge) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign short_pulse  = short_q;
    assign double_pulse = double_q;
    assign long_pulse   = long_q;
    assign repeat_pulse = repeat_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
